// File: rtl/chunk_sum_pkg.sv
// chunk_sum_pkg: declarations shared by the chunk_sum block.
//   state_t     - controller states (IDLE, RUN, DONE)
//   calc_n      - number of chunks N = width / chunk
//   calc_idx_w  - width of the chunk index register, $clog2(N) with a minimum of 1
package chunk_sum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_idx_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_sum_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry adder built from 1-bit
// full-adder cells.
//   a, b      - chunk operands
//   cin       - carry into bit 0
//   sum       - chunk sum
//   cout      - carry out of the top bit
//   c_msb_in  - carry into the top bit (feeds the signed-overflow flag)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunk_sum.sv
// chunk_sum: multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits
// per clock, LSB chunk first, holding the inter-chunk carry in a register.
//   in_clk    - clock, rising edge
//   in_rst    - synchronous active-high reset
//   in_start  - request, accepted in IDLE or DONE, ignored in RUN
//   in_a/in_b - operands, latched when start is accepted
//   in_cy     - carry-in, latched when start is accepted
//   in_sub    - 0: A+B+cy, 1: A+~B+cy (use in_cy=1 for A-B)
//   out_busy  - high while chunks are being processed
//   out_done  - one-cycle pulse when a result is presented
//   out_s     - registered result
//   out_cy    - carry out of the MSB (in subtract mode 1 = no borrow)
//   out_ovf   - signed overflow
// Latency from accepted start to out_done is N+1 cycles, N = WIDTH/CHUNK.
module chunk_sum
  import chunk_sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cy,
  input  logic             in_sub,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cy,
  output logic             out_ovf
);

  localparam int N     = calc_n(WIDTH, CHUNK);
  localparam int IDX_W = calc_idx_w(WIDTH, CHUNK);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

  state_t             state;
  logic [IDX_W-1:0]   k;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;      // already inverted for subtraction
  logic               carry;
  logic [WIDTH-1:0]   shadow;     // partial result, filled chunk by chunk

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   sum_chunk;
  logic               chunk_cout;
  logic               chunk_c_msb;
  logic [WIDTH-1:0]   s_merged;

  assign a_chunk = a_reg[k*CHUNK +: CHUNK];
  assign b_chunk = b_reg[k*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .a        (a_chunk),
    .b        (b_chunk),
    .cin      (carry),
    .sum      (sum_chunk),
    .cout     (chunk_cout),
    .c_msb_in (chunk_c_msb)
  );

  // Shadow result with the current chunk patched in, so the final chunk can
  // be presented on out_s in the same edge that enters DONE.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    s_merged = shadow;
    s_merged[k*CHUNK +: CHUNK] = sum_chunk;
  end

  // NOTE: state uses non-blocking assignments only; reset is sampled on the
  // clock edge, so every register here (including the operand copies) clears
  // synchronously.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      shadow   <= '0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_s    <= '0;
      out_cy   <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (in_start) begin
            a_reg    <= in_a;
            b_reg    <= in_sub ? ~in_b : in_b;
            carry    <= in_cy;
            k        <= '0;
            state    <= ST_RUN;
            out_busy <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          shadow <= s_merged;
          carry  <= chunk_cout;
          if (k == LAST_K) begin
            // Last chunk: its top-bit carries are those of bit WIDTH-1.
            k        <= '0;
            state    <= ST_DONE;
            out_busy <= 1'b0;
            out_done <= 1'b1;
            out_s    <= s_merged;
            out_cy   <= chunk_cout;
            out_ovf  <= chunk_c_msb ^ chunk_cout;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/chunk_sum.md
# chunk_sum

- Parametrised multi-cycle adder/subtractor, the successor to the fixed 4-bit ripple adder.
- Adds or subtracts two `WIDTH`-bit operands by processing `CHUNK` bits per clock, LSB chunk first.
- Carry is held in a register between chunks.
- Start/done handshake, registered results, carry-out and signed-overflow flags.
- Lets wide arithmetic share a short combinational carry chain in ALU and accumulator datapaths.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width; must be a multiple of `CHUNK`.
- `CHUNK`, 4: bits processed per cycle, 1..`WIDTH`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `in_clk`  in  1  clock, rising edge.
- `in_rst`  in  1  synchronous active-high reset.
- `in_start`  in  1  request; sampled only in IDLE or DONE.
- `in_a`  in  `WIDTH`  operand A; sampled when start is accepted.
- `in_b`  in  `WIDTH`  operand B; sampled when start is accepted.
- `in_cy`  in  1  carry-in; sampled when start is accepted.
- `in_sub`  in  1  0 = A+B+cy, 1 = A+~B+cy; sampled when start is accepted.
- `out_busy`  out  1  high in RUN.
- `out_done`  out  1  one-cycle pulse, high in DONE.
- `out_s`  out  `WIDTH`  result, registered.
- `out_cy`  out  1  carry out of MSB. In subtract mode, 1 = no borrow.
- `out_ovf`  out  1  signed overflow.

## Operation
States and transitions:
- IDLE → RUN on `in_start`. A, B (inverted if `in_sub`), `in_cy` latched; chunk index k=0.
- RUN: each cycle adds chunk k of A and B plus the carry register.
  - Sum chunk is written into the shadow result.
  - Carry register takes the chunk carry-out.
  - k increments.
  - After chunk N-1 (N=`WIDTH`/`CHUNK`), go to DONE.
- DONE: `out_s`, `out_cy` and `out_ovf` are loaded from the shadow registers; `out_done`=1.
  - Next state RUN if `in_start` (back-to-back operation), else IDLE.

Input handling:
- `in_start` is ignored in RUN, and operand inputs are don't-care there.
- Subtraction for A−B: drive `in_sub`=1, `in_cy`=1.

Flags:
- `out_ovf` = carry into bit `WIDTH`-1 XOR carry out of bit `WIDTH`-1.
- The carry into the MSB is captured during the last chunk.

Outputs and reset:
- Outputs hold their last values until the next DONE.
- Reset:
  - State IDLE, k=0, all internal registers 0.
  - `out_busy`, `out_done`, `out_s`, `out_cy` and `out_ovf` all 0.
  - Applies in any state; a reset during RUN abandons the operation and no `out_done` is produced.

Boundaries:
- N=1 (`CHUNK`=`WIDTH`): RUN lasts exactly one cycle.
- `CHUNK`=1: fully bit-serial, N=`WIDTH`.
- k wraps to 0 on leaving RUN.

## Timing
- Start sampled at the end of cycle 0.
- `out_busy` is high in cycles 1..N.
- `out_done` and valid outputs in cycle N+1.
- Latency is N+1 cycles.
- Throughput is one operation per N+1 cycles with `in_start` held.
- All outputs are registered. The combinational path is one `CHUNK`-bit ripple chain plus the carry register.

## Structure
Shared package `chunk_sum_pkg`:
- State enum (IDLE, RUN, DONE).
- Function computing N and the index width `$clog2(N)` (minimum 1).

Sub-module `chunk_adder`:
- Combinational `CHUNK`-bit ripple adder built from 1-bit full-adder cells.
- Ports: a, b, cin, sum, cout, and c_msb_in (carry into its top bit, used for `out_ovf`).
- Instantiated once.

## Test plan
- `WIDTH`=8, `CHUNK`=4: start with A=0x7F, B=0x01, cy=0, sub=0.
  - `out_busy` high in cycles 1–2; `out_done` in cycle 3.
  - `out_s`=0x80, `out_cy`=0, `out_ovf`=1.
- Subtraction A=0x10, B=0x20, sub=1, cy=1 → `out_s`=0xF0, `out_cy`=0 (borrow), `out_ovf`=0.
- A=0xFF, B=0x01, cy=1 → `out_s`=0x01, `out_cy`=1, `out_ovf`=0.
- `in_start` held continuously with new operands each DONE:
  - Done pulses in cycles 3, 6, 9, ….
  - A second start pulse issued during RUN (A=0x55) is ignored; the result reflects only the first operands.
- Reset asserted in cycle 2 of an operation:
  - Next cycle all outputs are 0 and state is IDLE.
  - No `out_done` follows.
  - A new start then completes normally.
- Parameter sweeps with A=0xA5, B=0x5A, cy=1 → `out_s`=0x00, `out_cy`=1, `out_ovf`=0:
  - `CHUNK`=1, `WIDTH`=8: done in cycle 9.
  - `CHUNK`=`WIDTH`=8: done in cycle 2.
